// File: rtl/vga_pkg.sv
// vga_pkg: shared text-screen geometry, 16-colour palette and char-map entry layout
package vga_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  typedef struct packed {
    logic [3:0] fg;
    logic [3:0] bg;
    logic [7:0] code;
  } map_entry_t;
  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };
  // Sum of two 5-bit rows can reach 60, so two conditional subtracts keep it below ROWS
  function automatic logic [4:0] wrap_row(input logic [5:0] s);
    logic [5:0] r;
    r = s >= 6'(ROWS) ? s - 6'(ROWS) : s;
    return r >= 6'(ROWS) ? 5'(r - 6'(ROWS)) : r[4:0];
  endfunction
endpackage

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: vsync falling-edge detect, frame-latched scroll row and cursor blink phase
module vga_frame_ctrl import vga_pkg::*; #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       vsync_in,
  input  logic [4:0] scroll_row,
  output logic [4:0] scroll_q,
  output logic       blink_phase
);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic          vsync_prev;
  logic [BW-1:0] blink_cnt;
  logic          frame_start;
  logic          blink_wrap;
  always_comb begin
    frame_start = pix_en & vsync_prev & ~vsync_in;
    blink_wrap  = blink_cnt == BW'(BLINK_FRAMES - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vsync_prev  <= 1'b1;
      scroll_q    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (pix_en) vsync_prev <= vsync_in;
      if (frame_start) begin
        scroll_q    <= scroll_row >= 5'(ROWS) ? 5'd0 : scroll_row;
        blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
        blink_phase <= blink_phase ^ blink_wrap;
      end
    end
endmodule

// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x30 text-mode pixel pipeline (char map -> glyph ROM -> palette) with
// scroll and blinking cursor; syncs and blank are delayed to stay aligned with the RGB output.
module vga_text_renderer import vga_pkg::*; #(
  parameter int H_START      = 158,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_n_in,
  input  logic [4:0]  scroll_row,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [11:0] map_addr,
  input  logic [15:0] map_data,
  output logic [11:0] glyph_addr,
  input  logic [7:0]  glyph_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_blank_n
);
  localparam int LW = $clog2(GLYPH_H);
  logic [4:0]    scroll_q;
  logic          blink_phase;
  logic [9:0]    x;
  logic [6:0]    col, col_a;
  logic [4:0]    row, row_eff;
  logic          oob, hit, pix;
  logic [3:0]    idx, idx2, fg1, bg1;
  logic [LW-1:0] line0;
  logic [2:0]    x0, x1;
  logic          hit0, hit1, oob0, oob1;
  logic [2:0]    hs, vs, bn;
  map_entry_t    ent;
  vga_frame_ctrl #(.BLINK_FRAMES(BLINK_FRAMES)) u_frame (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .vsync_in    (vsync_in),
    .scroll_row  (scroll_row),
    .scroll_q    (scroll_q),
    .blink_phase (blink_phase)
  );
  always_comb begin
    x       = hcount - 10'(H_START);
    col     = x[9:3];
    row     = vcount[8:4];
    row_eff = wrap_row({1'b0, row} + {1'b0, scroll_q});
    oob     = x >= 10'(COLS * GLYPH_W);
    col_a   = oob ? 7'd0 : col;
    hit     = cursor_en & blink_phase & (col == cursor_col) & (row == cursor_row);
    ent     = map_entry_t'(map_data);
    pix     = glyph_data[3'd7 - x1];
    idx     = oob1 ? 4'd0 : (pix ^ hit1) ? fg1 : bg1;
  end
  // Sync/blank shift registers idle high/high/low so reset never emits a spurious pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      map_addr    <= '0;
      line0       <= '0;
      x0          <= '0;
      hit0        <= 1'b0;
      oob0        <= 1'b0;
      glyph_addr  <= '0;
      fg1         <= '0;
      bg1         <= '0;
      x1          <= '0;
      hit1        <= 1'b0;
      oob1        <= 1'b0;
      idx2        <= '0;
      hs          <= '1;
      vs          <= '1;
      bn          <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_en) begin
      map_addr              <= 12'({row_eff, 6'b0}) + 12'({row_eff, 4'b0}) + 12'(col_a);
      line0                 <= vcount[LW-1:0];
      x0                    <= x[2:0];
      hit0                  <= hit;
      oob0                  <= oob;
      glyph_addr            <= {ent.code, line0};
      fg1                   <= ent.fg;
      bg1                   <= ent.bg;
      x1                    <= x0;
      hit1                  <= hit0;
      oob1                  <= oob0;
      idx2                  <= idx;
      hs                    <= {hs[1:0], hsync_in};
      vs                    <= {vs[1:0], vsync_in};
      bn                    <= {bn[1:0], blank_n_in};
      {vga_r, vga_g, vga_b} <= bn[2] ? PALETTE[idx2] : 24'd0;
      hsync                 <= hs[2];
      vsync                 <= vs[2];
      vga_blank_n           <= bn[2];
    end
endmodule
